uart_rx_fifo: RTL and testbench

// Receive half of the picosoc serial link. It samples UART_RX (8N1, LSB first) and

---
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/uart_rx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// SoC-facing side of uart_rx_fifo: FIFO read port plus the sticky error flags.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic [DEPTH_LOG2:0] level;
  logic                overrun;
  logic                frame_err;
  logic                clr_err;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, level, overrun, frame_err
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, level, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky
// overrun / framing error flags for the picosoc UART register block.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           rxd,
  uart_rx_fifo_if.slave  bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int DEPTH        = 2 ** DEPTH_LOG2;

  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                  rxMeta_q;
  logic                  rxs_q;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            sh_q, sh_d;
  logic                  frameErr_q, frameErr_d;
  logic                  overrun_q, overrun_d;
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            rdData_q, rdData_d;
  logic [7:0]            mem_q [DEPTH];

  logic pushEn;
  logic stopErr;
  logic doPush;
  logic doPop;
  logic dropByte;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxs_q    <= rxMeta_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pushEn  = 1'b0;
    stopErr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = S_DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = CNT_FULL;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            pushEn  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stopErr = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A push into a full FIFO survives only if a pop frees a slot in the same cycle.
  always_comb begin
    doPop    = bus.rd_en && (level_q != '0);
    doPush   = pushEn && ((level_q != LEVEL_FULL) || doPop);
    dropByte = pushEn && !doPush;

    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;

    case ({doPush, doPop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // The head register must see the byte being written when it becomes the new head.
    rdData_d = rdData_q;
    if (level_d != '0) begin
      if (doPush && (rdPtr_d == wrPtr_q)) begin
        rdData_d = sh_q;
      end else begin
        rdData_d = mem_q[rdPtr_d];
      end
    end

    frameErr_d = stopErr  ? 1'b1 : (bus.clr_err ? 1'b0 : frameErr_q);
    overrun_d  = dropByte ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      rdData_q   <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      rdData_q   <= rdData_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= sh_q;
    end
  end

  assign bus.rd_data   = rdData_q;
  assign bus.rd_valid  = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed corner cases, a vector table and
// randomized traffic compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_HZ       = 1600000;
  localparam int BAUD         = 100000;
  localparam int DEPTH_LOG2   = 4;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int DEPTH        = 2 ** DEPTH_LOG2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic rxd    = 1'b1;

  uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] expQ [$];
  logic       expOverrun  = 1'b0;
  logic       expFrameErr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    bit         popAfter;
    logic [4:0] expLevel;
    logic [7:0] expHead;
    logic       expFerr;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a good frame appends to the queue unless it holds DEPTH bytes; a same-cycle pop goes first.
  task automatic modelFrame(input logic [7:0] d, input logic stopBit, input bit popAtStop);
    if (popAtStop && expQ.size() > 0) void'(expQ.pop_front());
    if (!stopBit) expFrameErr = 1'b1;
    else if (expQ.size() == DEPTH) expOverrun = 1'b1;
    else expQ.push_back(d);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int holdBits,
                               input bit checkLat, input bit popAtStop);
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(CLKS_PER_BIT);
    for (int b = 0; b < 8; b++) begin
      rxd = d[b];
      tick(CLKS_PER_BIT);
    end
    rxd = stopBit;
    tick(10);
    if (checkLat) checkOutput("rd_valid before stop sample", 32'(bus.rd_valid), 32'd0);
    if (popAtStop) bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (checkLat) checkOutput("rd_valid after stop sample", 32'(bus.rd_valid), 32'd1);
    modelFrame(d, stopBit, popAtStop);
    tick(5);
    if (holdBits > 0) tick(holdBits * CLKS_PER_BIT);
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic popOne();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic clrErr();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    expOverrun  = 1'b0;
    expFrameErr = 1'b0;
  endtask

  task automatic drainAll();
    while (expQ.size() > 0) popOne();
    clrErr();
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(expQ.size() != 0));
    checkOutput({tag, " level"}, 32'(bus.level), 32'(expQ.size()));
    if (expQ.size() != 0) checkOutput({tag, " rd_data"}, 32'(bus.rd_data), 32'(expQ[0]));
    checkOutput({tag, " overrun"}, 32'(bus.overrun), 32'(expOverrun));
    checkOutput({tag, " frame_err"}, 32'(bus.frame_err), 32'(expFrameErr));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd0);
    checkOutput({tag, " level"}, 32'(bus.level), 32'd0);
    checkOutput({tag, " rd_data"}, 32'(bus.rd_data), 32'd0);
    checkOutput({tag, " overrun"}, 32'(bus.overrun), 32'd0);
    checkOutput({tag, " frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rdByte;
    logic [7:0] frameByte;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    vecs[0] = '{8'h12, 1'b1, 1'b0, 5'd1, 8'h12, 1'b0};
    vecs[1] = '{8'h34, 1'b0, 1'b0, 5'd1, 8'h12, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 5'd2, 8'h12, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 5'd2, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 5'd2, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 5'd1, 8'h80, 1'b1};

    tick(3);
    checkResetValues("in reset");
    resetn = 1'b1;
    tick(5);
    checkResetValues("after reset");

    // Single byte with exact push latency, then pop.
    applyStimulus(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    checkOutput("A5 level", 32'(bus.level), 32'd1);
    checkOutput("A5 rd_data", 32'(bus.rd_data), 32'hA5);
    popOne();
    checkOutput("A5 popped rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("A5 popped level", 32'(bus.level), 32'd0);

    // Short glitch must be rejected without side effects.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    compareModel("glitch");
    checkOutput("glitch level", 32'(bus.level), 32'd0);
    applyStimulus(8'h5A, 1'b1, 0, 1'b0, 1'b0);
    compareModel("after glitch");
    drainAll();

    // Framing error followed by a long break.
    applyStimulus(8'h3C, 1'b0, 40, 1'b0, 1'b0);
    checkOutput("break frame_err", 32'(bus.frame_err), 32'd1);
    checkOutput("break level", 32'(bus.level), 32'd0);
    applyStimulus(8'h55, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("post-break rd_data", 32'(bus.rd_data), 32'h55);
    compareModel("post-break");
    clrErr();
    checkOutput("clr frame_err", 32'(bus.frame_err), 32'd0);
    drainAll();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopBit, 0, 1'b0, 1'b0);
      if (vecs[i].popAfter) popOne();
      checkOutput($sformatf("vec%0d level", i), 32'(bus.level), 32'(vecs[i].expLevel));
      if (vecs[i].expLevel != 0)
        checkOutput($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].expHead));
      checkOutput($sformatf("vec%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].expFerr));
    end
    drainAll();

    // Seventeen bytes into a sixteen-entry FIFO.
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 0, 1'b0, 1'b0);
    checkOutput("fill level", 32'(bus.level), 32'd16);
    checkOutput("fill overrun", 32'(bus.overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain byte %0d", i), 32'(bus.rd_data), 32'(i));
      popOne();
    end
    checkOutput("drained rd_valid", 32'(bus.rd_valid), 32'd0);
    clrErr();

    // Push and pop on the same cycle while full.
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i), 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(8'h77, 1'b1, 0, 1'b0, 1'b1);
    checkOutput("full push+pop level", 32'(bus.level), 32'd16);
    checkOutput("full push+pop overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rdByte = (i == 15) ? 8'h77 : 8'(8'h21 + i);
      checkOutput($sformatf("wrap byte %0d", i), 32'(bus.rd_data), 32'(rdByte));
      popOne();
    end
    drainAll();

    // Reset in the middle of a frame.
    applyStimulus(8'h99, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(8'h66, 1'b0, 0, 1'b0, 1'b0);
    compareModel("pre-reset");
    frameByte = 8'h81;
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(CLKS_PER_BIT);
    for (int b = 0; b < 3; b++) begin
      rxd = frameByte[b];
      tick(CLKS_PER_BIT);
    end
    rxd = frameByte[3];
    tick(5);
    resetn = 1'b0;
    tick(2);
    checkResetValues("mid-frame reset");
    rxd = 1'b1;
    tick(2);
    resetn = 1'b1;
    expQ.delete();
    expOverrun  = 1'b0;
    expFrameErr = 1'b0;
    tick(40);
    checkResetValues("after mid-frame reset");
    applyStimulus(8'h81, 1'b1, 0, 1'b0, 1'b0);
    checkOutput("0x81 rd_data", 32'(bus.rd_data), 32'h81);
    compareModel("0x81");
    drainAll();

    // Randomized traffic against the queue model.
    for (int it = 0; it < 30; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act <= 5) applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 0, 1'b0, 1'b0);
      else if (act <= 7) popOne();
      else if (act == 8) clrErr();
      else applyStimulus(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b1);
      compareModel($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
